video_layer_compositor: RTL

Parametrised successor to the hard-wired two-sprite mux and fixed sync pipes in the HDMI top level. Accepts NUM_LAYERS pixel sources, each with its own pipeline latency, and re-aligns them to a common depth. It composites them (single-select, colour-key overlay or blank) and emits RGB plus matching hs/vs/ad/nf, ready for the TMDS encoders. Layer and mode changes are applied only at the aligned frame boundary, so no frame is ever torn.

---
 rtl/video_pkg.sv | 53 +++++
 rtl/video_layer_compositor_pipe_delay.sv | 38 +++
 rtl/video_layer_compositor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types and elaboration-time helpers for the video layer compositor.
//   rgb_t       : 24-bit pixel {r, g, b}
//   comp_mode_t : composition mode held in the active configuration
//   max_lat     : largest per-layer latency in a packed latency vector
//   lat_at      : latency of one layer from a packed latency vector
//   decode_mode : maps the 2-bit mode request onto comp_mode_t (3 aliases SELECT)
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    OVERLAY = 2'd1,
    BLANK   = 2'd2
  } comp_mode_t;

  // Latency vectors are passed zero-extended to 256 bits so one function
  // serves every NUM_LAYERS/LAT_W combination.
  function automatic int unsigned lat_at(input logic [255:0] lat,
                                         input int unsigned idx,
                                         input int unsigned w);
    int unsigned v;
    v = 0;
    for (int unsigned b = 0; b < w; b++) begin
      if (lat[idx*w + b]) v = v | (32'd1 << b);
    end
    return v;
  endfunction

  function automatic int unsigned max_lat(input logic [255:0] lat,
                                          input int unsigned n,
                                          input int unsigned w);
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (lat_at(lat, i, w) > m) m = lat_at(lat, i, w);
    end
    return m;
  endfunction

  function automatic comp_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return OVERLAY;
      2'd2:    return BLANK;
      default: return SELECT;
    endcase
  endfunction

endpackage

// File: rtl/video_layer_compositor_pipe_delay.sv
// pipe_delay: fixed-depth shift register with asynchronous active-low clear.
//   clk   : clock
//   rst_n : asynchronous clear, active-low
//   d     : WIDTH-bit input
//   q     : d delayed by DEPTH cycles (DEPTH=0 is a plain wire)
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH*WIDTH-1:0] sr;

    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= d;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[(DEPTH-1)*WIDTH-1:0], d};
      end
    end

    assign q = sr[DEPTH*WIDTH-1 -: WIDTH];
  end

endmodule

// File: rtl/video_layer_compositor.sv
// video_layer_compositor: aligns NUM_LAYERS pixel sources of differing
// latency to a common depth, composites them and emits RGB plus matching syncs.
//   clk_pixel_in, rst_in (async, active-low)
//   hs_in/vs_in/ad_in/nf_in : sync sample from the timing generator
//   pix_in   : layer i at [24*i +: 24], LAYER_LAT[i] cycles behind its sync
//   sel_in   : layer requested for SELECT mode
//   mode_in  : 0/3 SELECT, 1 OVERLAY, 2 BLANK
//   red/green/blue_out, hs/vs/ad/nf_out : registered, D_MAX+1 after the sync
//   active_sel_out/active_mode_out     : configuration in effect
//   cfg_err_out : one-cycle pulse with nf_out when sel_in was out of range
module video_layer_compositor
  import video_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned LAT_W = 4,
  parameter logic [NUM_LAYERS*LAT_W-1:0] LAYER_LAT = {4'd5, 4'd3},
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  localparam int unsigned SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    clk_pixel_in,
  input  logic                    rst_in,
  input  logic                    hs_in,
  input  logic                    vs_in,
  input  logic                    ad_in,
  input  logic                    nf_in,
  input  logic [24*NUM_LAYERS-1:0] pix_in,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [1:0]              mode_in,
  output logic [7:0]              red_out,
  output logic [7:0]              green_out,
  output logic [7:0]              blue_out,
  output logic                    hs_out,
  output logic                    vs_out,
  output logic                    ad_out,
  output logic                    nf_out,
  output logic [SEL_W-1:0]        active_sel_out,
  output logic [1:0]              active_mode_out,
  output logic                    cfg_err_out
);

  localparam int unsigned D_MAX = max_lat(256'(LAYER_LAT), NUM_LAYERS, LAT_W);

  logic [3:0]       sync_a;
  logic             ad_a;
  logic             nf_a;
  logic [SEL_W-1:0] active_sel;
  comp_mode_t       active_mode;
  logic [SEL_W-1:0] eff_sel;
  comp_mode_t       eff_mode;
  logic             sel_bad;
  rgb_t             pix_next;
  rgb_t             pix_q;

  // Per-layer alignment plus two priority chains: the overlay chain keeps the
  // highest-index non-key layer (falling back to layer 0), the select chain
  // picks the layer matching eff_sel.
  logic [24*NUM_LAYERS-1:0] aligned;
  rgb_t                     ovl_chain [NUM_LAYERS];
  rgb_t                     sel_chain [NUM_LAYERS];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    localparam int unsigned DEPTH = D_MAX - lat_at(256'(LAYER_LAT), i, LAT_W);

    pipe_delay #(.WIDTH(24), .DEPTH(DEPTH)) u_dly (
      .clk   (clk_pixel_in),
      .rst_n (rst_in),
      .d     (pix_in[24*i +: 24]),
      .q     (aligned[24*i +: 24])
    );

    if (i == 0) begin : g_first
      assign ovl_chain[0] = aligned[23:0];
      assign sel_chain[0] = aligned[23:0];
    end else begin : g_next
      assign ovl_chain[i] = (aligned[24*i +: 24] != KEY_COLOR) ? aligned[24*i +: 24]
                                                                : ovl_chain[i-1];
      assign sel_chain[i] = (32'(eff_sel) == i) ? aligned[24*i +: 24] : sel_chain[i-1];
    end
  end

  pipe_delay #(.WIDTH(4), .DEPTH(D_MAX)) u_sync (
    .clk   (clk_pixel_in),
    .rst_n (rst_in),
    .d     ({hs_in, vs_in, ad_in, nf_in}),
    .q     (sync_a)
  );

  assign ad_a    = sync_a[1];
  assign nf_a    = sync_a[0];
  assign sel_bad = (32'(sel_in) >= NUM_LAYERS);

  // The configuration loaded on an nf_a cycle already governs that cycle.
  always_comb begin
    eff_sel  = active_sel;
    eff_mode = active_mode;
    if (nf_a) begin
      eff_mode = decode_mode(mode_in);
      if (!sel_bad) eff_sel = sel_in;
    end
  end

  always_comb begin
    pix_next = '0;
    if (ad_a) begin
      case (eff_mode)
        SELECT:  pix_next = sel_chain[NUM_LAYERS-1];
        OVERLAY: pix_next = ovl_chain[NUM_LAYERS-1];
        default: pix_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      pix_q       <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      ad_out      <= 1'b0;
      nf_out      <= 1'b0;
      active_sel  <= '0;
      active_mode <= SELECT;
      cfg_err_out <= 1'b0;
    end else begin
      pix_q       <= pix_next;
      hs_out      <= sync_a[3];
      vs_out      <= sync_a[2];
      ad_out      <= sync_a[1];
      nf_out      <= sync_a[0];
      active_sel  <= eff_sel;
      active_mode <= eff_mode;
      cfg_err_out <= nf_a & sel_bad;
    end
  end

  assign red_out         = pix_q.r;
  assign green_out       = pix_q.g;
  assign blue_out        = pix_q.b;
  assign active_sel_out  = active_sel;
  assign active_mode_out = active_mode;

endmodule
